pipeline_stall_ctrl: RTL and testbench

- Consumer side of the load-use stall request: turns hazard `stall` pulses, EX-stage taken-branch redirects and data-memory busy into per-stage pipeline enables.
- Drives PC write, IF/ID write/flush, ID/EX bubble insertion and back-end hold.
- Sits in the RV32IC core control path between hazard detection, the EX branch unit, the data-memory interface and the pipeline registers.

---
 rtl/pipeline_stall_ctrl_pkg.sv | 49 ++++
 rtl/pipeline_stall_ctrl_if.sv | 47 ++++
 rtl/pipeline_stall_ctrl_stall_watchdog.sv | 47 ++++
 rtl/pipeline_stall_ctrl.sv | 176 +++++++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared control definitions for the pipeline stall controller: FSM state encodings,
// the NOP loaded by an IF/ID flush, parameter defaults and counter widths.
package pipeline_stall_ctrl_pkg;

   // Controller FSM state encodings; 2'd3 is unused and recovers to RUN.
   localparam logic [1:0] RUN        = 2'd0;
   localparam logic [1:0] FLUSH      = 2'd1;
   localparam logic [1:0] MEM_WAIT   = 2'd2;
   localparam logic [1:0] ST_UNUSED  = 2'd3;

   // addi x0, x0, 0 -- instruction word the IF/ID register loads when flushed.
   localparam logic [31:0] NOP_INSN = 32'h0000_0013;

   localparam int unsigned FLUSH_CYCLES_DEF = 2;
   localparam int unsigned MAX_STALL_DEF    = 15;

   localparam int unsigned PERF_CNT_W  = 32;
   localparam int unsigned FLUSH_CNT_W = 3;
   localparam int unsigned STALL_CNT_W = 8;

   // Per-stage enable bundle driven onto the pipeline registers.
   typedef struct packed {
      logic pc_write;
      logic if_id_write;
      logic if_id_flush;
      logic id_ex_bubble;
      logic pipe_hold;
   } stage_en_t;

   localparam stage_en_t EN_IDLE = '{
      pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0, id_ex_bubble: 1'b0, pipe_hold: 1'b0
   };
   localparam stage_en_t EN_STALL = '{
      pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0, id_ex_bubble: 1'b1, pipe_hold: 1'b0
   };
   localparam stage_en_t EN_BRANCH = '{
      pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1, id_ex_bubble: 1'b1, pipe_hold: 1'b0
   };
   localparam stage_en_t EN_FLUSH = '{
      pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1, id_ex_bubble: 1'b0, pipe_hold: 1'b0
   };
   localparam stage_en_t EN_FREEZE = '{
      pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0, id_ex_bubble: 1'b0, pipe_hold: 1'b1
   };
   localparam stage_en_t EN_RESET = '{
      pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b1, id_ex_bubble: 1'b1, pipe_hold: 1'b0
   };

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Handshake bundle between the stall controller and the surrounding core control path.
// Optional macro STALL_PERF_CNT_EN adds the performance counter outputs.
interface pipeline_stall_ctrl_if;
   import pipeline_stall_ctrl_pkg::*;

   logic       stall_req;
   logic       branch_taken;
   logic       mem_busy;
   logic       pc_write;
   logic       if_id_write;
   logic       if_id_flush;
   logic       id_ex_bubble;
   logic       pipe_hold;
   logic       stall_timeout;
   logic [1:0] ctrl_state;
`ifdef STALL_PERF_CNT_EN
   logic [PERF_CNT_W-1:0] perf_stall_cnt;
   logic [PERF_CNT_W-1:0] perf_flush_cnt;

   // Hazard/branch/memory side: drives requests, observes enables.
   modport master (
      output stall_req, branch_taken, mem_busy,
      input  pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold, stall_timeout,
      input  ctrl_state, perf_stall_cnt, perf_flush_cnt
   );

   // Stall controller side.
   modport slave (
      input  stall_req, branch_taken, mem_busy,
      output pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold, stall_timeout,
      output ctrl_state, perf_stall_cnt, perf_flush_cnt
   );
`else
   modport master (
      output stall_req, branch_taken, mem_busy,
      input  pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold, stall_timeout,
      input  ctrl_state
   );

   modport slave (
      input  stall_req, branch_taken, mem_busy,
      output pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold, stall_timeout,
      output ctrl_state
   );
`endif

endinterface

// File: rtl/pipeline_stall_ctrl_stall_watchdog.sv
// Saturating consecutive-stall counter with a sticky timeout flag. Kept generic so the
// fetch side can reuse it for its own stall sources.
module pipeline_stall_ctrl_stall_watchdog
   import pipeline_stall_ctrl_pkg::*;
#(
   parameter int unsigned MAX_STALL = MAX_STALL_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic stall_grant_i,
   input  logic hold_i,
   output logic stall_timeout_o
);

   localparam logic [STALL_CNT_W-1:0] MaxStallW = STALL_CNT_W'(MAX_STALL);

   logic [STALL_CNT_W-1:0] stall_cnt_d, stall_cnt_q;
   logic                   timeout_d, timeout_q;

   // Count granted stalls, hold while frozen, clear otherwise; flag sets once the run
   // exceeds the limit and only reset clears it.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall_grant_i) begin
         if (stall_cnt_q != {STALL_CNT_W{1'b1}}) begin
            stall_cnt_d = stall_cnt_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
         end
      end else if (!hold_i) begin
         stall_cnt_d = '0;
      end
      timeout_d = timeout_q | (stall_cnt_d > MaxStallW);
   end

   // Counter and sticky flag registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= '0;
         timeout_q   <= 1'b0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         timeout_q   <= timeout_d;
      end
   end

   assign stall_timeout_o = timeout_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall controller: converts load-use stall requests, EX taken-branch redirects
// and data-memory busy into per-stage enables. Priority is mem_busy > branch > stall.
// Optional macro STALL_PERF_CNT_EN adds granted-stall and accepted-branch counters.
module pipeline_stall_ctrl
   import pipeline_stall_ctrl_pkg::*;
#(
   parameter int unsigned FLUSH_CYCLES = FLUSH_CYCLES_DEF,
   parameter int unsigned MAX_STALL    = MAX_STALL_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   pipeline_stall_ctrl_if.slave bus
);

   localparam logic [FLUSH_CNT_W-1:0] FlushReload = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
   localparam logic [FLUSH_CNT_W-1:0] FlushLast   = FLUSH_CNT_W'(1);
   localparam logic [FLUSH_CNT_W-1:0] FlushStep   = FLUSH_CNT_W'(1);

   logic [1:0]             state_d, state_q;
   logic [FLUSH_CNT_W-1:0] flush_cnt_d, flush_cnt_q;
   logic [1:0]             saved_state_d, saved_state_q;
   logic [FLUSH_CNT_W-1:0] saved_cnt_d, saved_cnt_q;

   logic [1:0]             eff_state;
   logic [FLUSH_CNT_W-1:0] eff_cnt;
   stage_en_t              en;
   stage_en_t              en_out;
   logic                   stall_grant;
   logic                   branch_accept;
   logic                   wd_hold;

   // State the pipeline behaves as this cycle: MEM_WAIT resumes the saved state at once,
   // the unused encoding falls back to RUN.
   always_comb begin
      eff_state = state_q;
      eff_cnt   = flush_cnt_q;
      if (state_q == MEM_WAIT) begin
         eff_state = saved_state_q;
         eff_cnt   = saved_cnt_q;
      end else if (state_q == ST_UNUSED) begin
         eff_state = RUN;
         eff_cnt   = '0;
      end
   end

   // Next-state, flush counter and stage enables by input priority.
   always_comb begin
      state_d       = eff_state;
      flush_cnt_d   = eff_cnt;
      saved_state_d = saved_state_q;
      saved_cnt_d   = saved_cnt_q;
      en            = EN_IDLE;
      stall_grant   = 1'b0;
      branch_accept = 1'b0;

      if (bus.mem_busy) begin
         en          = EN_FREEZE;
         state_d     = MEM_WAIT;
         flush_cnt_d = flush_cnt_q;
         // Only the first frozen cycle captures the state to resume into.
         if (state_q != MEM_WAIT) begin
            saved_state_d = eff_state;
            saved_cnt_d   = eff_cnt;
         end
      end else begin
         case (eff_state)
            FLUSH: begin
               // The instruction in ID is being squashed, so stall_req is meaningless here.
               en = EN_FLUSH;
               if (bus.branch_taken) begin
                  branch_accept = 1'b1;
                  flush_cnt_d   = FlushReload;
               end else if (eff_cnt <= FlushLast) begin
                  state_d     = RUN;
                  flush_cnt_d = '0;
               end else begin
                  flush_cnt_d = eff_cnt - FlushStep;
               end
            end
            default: begin
               if (bus.branch_taken) begin
                  en            = EN_BRANCH;
                  branch_accept = 1'b1;
                  if (FLUSH_CYCLES > 1) begin
                     state_d     = FLUSH;
                     flush_cnt_d = FlushReload;
                  end else begin
                     state_d     = RUN;
                     flush_cnt_d = '0;
                  end
               end else if (bus.stall_req) begin
                  en          = EN_STALL;
                  stall_grant = 1'b1;
                  state_d     = RUN;
                  flush_cnt_d = '0;
               end else begin
                  state_d     = RUN;
                  flush_cnt_d = '0;
               end
            end
         endcase
      end
   end

   // Reset forces a safe bubble/flush pattern before any clock edge.
   always_comb begin
      en_out = rst ? EN_RESET : en;
   end

   // FSM, flush counter and the pre-freeze snapshot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= RUN;
         flush_cnt_q   <= '0;
         saved_state_q <= RUN;
         saved_cnt_q   <= '0;
      end else begin
         state_q       <= state_d;
         flush_cnt_q   <= flush_cnt_d;
         saved_state_q <= saved_state_d;
         saved_cnt_q   <= saved_cnt_d;
      end
   end

   // The stall run survives a memory freeze, including the resume cycle.
   assign wd_hold = bus.mem_busy | (state_q == MEM_WAIT);

   pipeline_stall_ctrl_stall_watchdog #(
      .MAX_STALL (MAX_STALL)
   ) u_stall_watchdog (
      .clk             (clk),
      .rst             (rst),
      .stall_grant_i   (stall_grant),
      .hold_i          (wd_hold),
      .stall_timeout_o (bus.stall_timeout)
   );

   assign bus.pc_write     = en_out.pc_write;
   assign bus.if_id_write  = en_out.if_id_write;
   assign bus.if_id_flush  = en_out.if_id_flush;
   assign bus.id_ex_bubble = en_out.id_ex_bubble;
   assign bus.pipe_hold    = en_out.pipe_hold;
   assign bus.ctrl_state   = state_q;

`ifdef STALL_PERF_CNT_EN
   logic [PERF_CNT_W-1:0] perf_stall_cnt_d, perf_stall_cnt_q;
   logic [PERF_CNT_W-1:0] perf_flush_cnt_d, perf_flush_cnt_q;

   // Free-running event counters, wrapping modulo 2^32.
   always_comb begin
      perf_stall_cnt_d = perf_stall_cnt_q;
      perf_flush_cnt_d = perf_flush_cnt_q;
      if (stall_grant) begin
         perf_stall_cnt_d = perf_stall_cnt_q + {{(PERF_CNT_W-1){1'b0}}, 1'b1};
      end
      if (branch_accept) begin
         perf_flush_cnt_d = perf_flush_cnt_q + {{(PERF_CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // Performance counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_stall_cnt_q <= '0;
         perf_flush_cnt_q <= '0;
      end else begin
         perf_stall_cnt_q <= perf_stall_cnt_d;
         perf_flush_cnt_q <= perf_flush_cnt_d;
      end
   end

   assign bus.perf_stall_cnt = perf_stall_cnt_q;
   assign bus.perf_flush_cnt = perf_flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: directed vector table, hand-written reset
// and watchdog sequences, then randomized traffic against a behavioural model.
module tb_pipeline_stall_ctrl;

   localparam int FC = 2;
   localparam int MS = 15;

   logic clk = 1'b0;
   logic rst = 1'b1;

   pipeline_stall_ctrl_if bus ();

   pipeline_stall_ctrl #(
      .FLUSH_CYCLES (FC),
      .MAX_STALL    (MS)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Model state: remaining flush cycles, whether the previous cycle was frozen,
   // current consecutive-stall run, sticky timeout and event counts.
   int          m_flush_left;
   bit          m_prev_mb;
   int          m_stall;
   bit          m_to;
   int unsigned m_perf_stall;
   int unsigned m_perf_flush;

   // {sb, br, mb} stimulus with expected {pc, ifw, flush, bubble, hold, state[1:0]}.
   typedef struct packed {
      logic       sb;
      logic       br;
      logic       mb;
      logic [6:0] out;
   } vec_t;

   localparam int NVEC = 19;
   vec_t tbl [NVEC];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [6:0] dut_out();
      return {bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_bubble, bus.pipe_hold,
              bus.ctrl_state};
   endfunction

   task automatic model_reset();
      m_flush_left = 0;
      m_prev_mb    = 1'b0;
      m_stall      = 0;
      m_to         = 1'b0;
      m_perf_stall = 0;
      m_perf_flush = 0;
   endtask

   function automatic logic [6:0] model_out(input bit sb, input bit br, input bit mb);
      logic [1:0] st;
      if (m_prev_mb) st = 2'd2;
      else if (m_flush_left > 0) st = 2'd1;
      else st = 2'd0;
      if (mb) return {5'b00001, st};
      if (m_flush_left > 0) return {5'b11100, st};
      if (br) return {5'b11110, st};
      if (sb) return {5'b00010, st};
      return {5'b11000, st};
   endfunction

   task automatic model_advance(input bit sb, input bit br, input bit mb);
      bit grant;
      grant = 1'b0;
      if (!mb) begin
         if (br) begin
            m_flush_left = FC - 1;
            m_perf_flush++;
         end else if (m_flush_left > 0) begin
            m_flush_left--;
         end else if (sb) begin
            grant = 1'b1;
         end
      end
      if (grant) begin
         m_stall = (m_stall < 255) ? m_stall + 1 : 255;
         m_perf_stall++;
      end else if (!(mb || m_prev_mb)) begin
         m_stall = 0;
      end
      if (m_stall > MS) m_to = 1'b1;
      m_prev_mb = mb;
   endtask

   // One cycle: drive after the falling edge, sample 1 ns later, then step the model.
   task automatic step(input bit sb, input bit br, input bit mb,
                       output logic [6:0] act, output logic act_to,
                       output logic [6:0] exp, output logic exp_to);
      @(negedge clk);
      bus.stall_req    = sb;
      bus.branch_taken = br;
      bus.mem_busy     = mb;
      #1;
      act    = dut_out();
      act_to = bus.stall_timeout;
      exp    = model_out(sb, br, mb);
      exp_to = m_to;
      model_advance(sb, br, mb);
   endtask

   task automatic do_reset();
      @(negedge clk);
      bus.stall_req    = 1'b0;
      bus.branch_taken = 1'b0;
      bus.mem_busy     = 1'b0;
      rst = 1'b1;
      #2;
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      logic [6:0] a, e;
      logic       ato, eto;
      bit         sb, br, mb;
      int         sb_pct, br_pct;

      bus.stall_req    = 1'b0;
      bus.branch_taken = 1'b0;
      bus.mem_busy     = 1'b0;
      model_reset();

      tbl[0]  = '{sb: 1'b0, br: 1'b0, mb: 1'b0, out: 7'b11000_00};
      tbl[1]  = '{sb: 1'b1, br: 1'b0, mb: 1'b0, out: 7'b00010_00};
      tbl[2]  = '{sb: 1'b0, br: 1'b0, mb: 1'b0, out: 7'b11000_00};
      tbl[3]  = '{sb: 1'b0, br: 1'b1, mb: 1'b0, out: 7'b11110_00};
      tbl[4]  = '{sb: 1'b1, br: 1'b0, mb: 1'b0, out: 7'b11100_01};
      tbl[5]  = '{sb: 1'b0, br: 1'b0, mb: 1'b0, out: 7'b11000_00};
      tbl[6]  = '{sb: 1'b0, br: 1'b1, mb: 1'b0, out: 7'b11110_00};
      tbl[7]  = '{sb: 1'b0, br: 1'b0, mb: 1'b1, out: 7'b00001_01};
      tbl[8]  = '{sb: 1'b0, br: 1'b0, mb: 1'b1, out: 7'b00001_10};
      tbl[9]  = '{sb: 1'b0, br: 1'b0, mb: 1'b1, out: 7'b00001_10};
      tbl[10] = '{sb: 1'b0, br: 1'b0, mb: 1'b0, out: 7'b11100_10};
      tbl[11] = '{sb: 1'b0, br: 1'b0, mb: 1'b0, out: 7'b11000_00};
      tbl[12] = '{sb: 1'b1, br: 1'b1, mb: 1'b1, out: 7'b00001_00};
      tbl[13] = '{sb: 1'b0, br: 1'b0, mb: 1'b0, out: 7'b11000_10};
      tbl[14] = '{sb: 1'b0, br: 1'b0, mb: 1'b0, out: 7'b11000_00};
      tbl[15] = '{sb: 1'b0, br: 1'b1, mb: 1'b0, out: 7'b11110_00};
      tbl[16] = '{sb: 1'b0, br: 1'b1, mb: 1'b0, out: 7'b11100_01};
      tbl[17] = '{sb: 1'b0, br: 1'b0, mb: 1'b0, out: 7'b11100_01};
      tbl[18] = '{sb: 1'b0, br: 1'b0, mb: 1'b0, out: 7'b11000_00};

      // Power-on reset, no clock edge yet.
      #3;
      check("por_outputs", 32'(dut_out()), 32'(7'b00110_00));
      check("por_timeout", 32'(bus.stall_timeout), 32'd0);
      @(negedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("por_release_idle", 32'(dut_out()), 32'(7'b11000_00));

      // Directed vectors.
      for (int i = 0; i < NVEC; i++) begin
         step(tbl[i].sb, tbl[i].br, tbl[i].mb, a, ato, e, eto);
         check($sformatf("vec[%0d]", i), 32'(a), 32'(tbl[i].out));
         check($sformatf("vec_to[%0d]", i), 32'(ato), 32'd0);
      end

      // Asynchronous reset mid-cycle while in FLUSH.
      step(1'b0, 1'b1, 1'b0, a, ato, e, eto);
      @(negedge clk);
      bus.branch_taken = 1'b0;
      #1;
      check("pre_reset_state", 32'(bus.ctrl_state), 32'd1);
      #1;
      rst = 1'b1;
      #1;
      check("async_reset_outputs", 32'(dut_out()), 32'(7'b00110_00));
      @(negedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("reset_release_idle", 32'(dut_out()), 32'(7'b11000_00));
      model_reset();

      // Watchdog: 16 consecutive granted stalls trip the sticky timeout.
      for (int i = 0; i < 16; i++) begin
         step(1'b1, 1'b0, 1'b0, a, ato, e, eto);
         check($sformatf("wd_stall_out[%0d]", i), 32'(a), 32'(7'b00010_00));
         check($sformatf("wd_timeout_low[%0d]", i), 32'(ato), 32'd0);
      end
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b0, 1'b0, a, ato, e, eto);
         check($sformatf("wd_idle_out[%0d]", i), 32'(a), 32'(7'b11000_00));
         check($sformatf("wd_timeout_sticky[%0d]", i), 32'(ato), 32'd1);
      end
`ifdef STALL_PERF_CNT_EN
      check("perf_stall_16", bus.perf_stall_cnt, 32'd16);
      check("perf_flush_0", bus.perf_flush_cnt, 32'd0);
`endif

      // Randomized traffic against the model; odd segments are stall-heavy.
      do_reset();
      for (int i = 0; i < 800; i++) begin
         sb_pct = ((i / 100) % 2 == 1) ? 95 : 40;
         br_pct = ((i / 100) % 2 == 1) ? 4 : 15;
         mb = ($urandom_range(99) < 15);
         br = ($urandom_range(99) < br_pct);
         sb = ($urandom_range(99) < sb_pct);
         step(sb, br, mb, a, ato, e, eto);
         check($sformatf("rand_out[%0d]", i), 32'(a), 32'(e));
         check($sformatf("rand_to[%0d]", i), 32'(ato), 32'(eto));
      end
      @(negedge clk);
      bus.stall_req    = 1'b0;
      bus.branch_taken = 1'b0;
      bus.mem_busy     = 1'b0;
      #1;
`ifdef STALL_PERF_CNT_EN
      check("rand_perf_stall", bus.perf_stall_cnt, m_perf_stall);
      check("rand_perf_flush", bus.perf_flush_cnt, m_perf_flush);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
